// File: rtl/int8mm_pkg.sv
// Shared types and helpers for the int8_nxn_stream_mm matrix-multiply block.
// Optional feature macro: INT8MM_SATURATE_EN (clamp accumulator results instead of wrapping).
package int8mm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV_A,
    S_RECV_B,
    S_COMPUTE,
    S_SEND_C,
    S_DONE
  } state_e;

  // Width of one packed A row / B column beat.
  function automatic int row_w(input int dim);
    return dim * 8;
  endfunction

  // Width of one packed C row beat.
  function automatic int c_row_w(input int dim, input int acc_w);
    return dim * acc_w;
  endfunction

  // Width of a row/column index.
  function automatic int idx_w(input int dim);
    return $clog2(dim);
  endfunction

  // Width of a dot-product result: 16-bit products plus growth for DIM terms.
  function automatic int dot_w(input int dim);
    return 16 + $clog2(dim);
  endfunction

  // Reduce a wide signed accumulator sum to acc_w bits; the caller keeps the low acc_w bits.
  function automatic logic signed [63:0] acc_reduce(input logic signed [64:0] sum,
                                                    input int acc_w);
`ifdef INT8MM_SATURATE_EN
    logic signed [64:0] max_v;
    logic signed [64:0] min_v;
    max_v = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
    min_v = -(65'sd1 <<< (acc_w - 1));
    if (sum > max_v) begin
      return max_v[63:0];
    end else if (sum < min_v) begin
      return min_v[63:0];
    end
    return sum[63:0];
`else
    return sum[63:0];
`endif
  endfunction

endpackage

// File: rtl/int8_dot_lane.sv
// One dot-product lane: DIM parallel 8x8 multipliers feeding a reduction sum,
// with a single registered output that advances only when ce is high.
module int8_dot_lane
  import int8mm_pkg::*;
#(
  parameter int DIM   = 8,
  parameter int DOT_W = dot_w(DIM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 mode_signed,
  input  logic [DIM*8-1:0]     a_row,
  input  logic [DIM*8-1:0]     b_col,
  output logic [DOT_W-1:0]     dot_q
);

  logic [DOT_W-1:0] dot_d;

  // Multiply each operand pair as 9-bit signed values and sum modulo 2^DOT_W (the true result always fits).
  always_comb begin
    logic signed [8:0]       a_e;
    logic signed [8:0]       b_e;
    logic signed [17:0]      prod;
    logic signed [DOT_W-1:0] sum;
    sum = '0;
    for (int k = 0; k < DIM; k++) begin
      a_e  = {mode_signed & a_row[k*8+7], a_row[k*8 +: 8]};
      b_e  = {mode_signed & b_col[k*8+7], b_col[k*8 +: 8]};
      prod = a_e * b_e;
      sum  = sum + DOT_W'(prod);
    end
    dot_d = sum;
  end

  // Output register, frozen while the clock enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dot_q <= '0;
    end else if (ce) begin
      dot_q <= dot_d;
    end
  end

endmodule

// File: rtl/int8_nxn_stream_mm.sv
// DIMxDIM INT8 matrix multiply with ap_ctrl_chain block control and stream ports.
// Optional feature macro: INT8MM_SATURATE_EN (see int8mm_pkg::acc_reduce).
module int8_nxn_stream_mm
  import int8mm_pkg::*;
#(
  parameter int DIM   = 8,
  parameter int ACC_W = 32
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   ap_ce,
  input  logic                   ap_start,
  input  logic                   ap_continue,
  output logic                   ap_idle,
  output logic                   ap_ready,
  output logic                   ap_done,
  input  logic                   mode_signed,
  input  logic                   acc_en,
  input  logic [DIM*8-1:0]       a_tdata,
  input  logic                   a_tvalid,
  output logic                   a_tready,
  input  logic [DIM*8-1:0]       b_tdata,
  input  logic                   b_tvalid,
  output logic                   b_tready,
  output logic [DIM*ACC_W-1:0]   c_tdata,
  output logic                   c_tvalid,
  output logic                   c_tlast,
  input  logic                   c_tready
);

  localparam int ROW_W  = row_w(DIM);
  localparam int CROW_W = c_row_w(DIM, ACC_W);
  localparam int IDX_W  = idx_w(DIM);
  localparam int DOT_W  = dot_w(DIM);
  localparam int SUM_W  = ((ACC_W > DOT_W) ? ACC_W : DOT_W) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        beat_q, beat_d;
  logic [IDX_W-1:0]        iss_i_q, iss_i_d, iss_j_q, iss_j_d;
  logic                    iss_done_q, iss_done_d;
  logic                    wr_vld_q, wr_vld_d;
  logic [IDX_W-1:0]        wr_i_q, wr_i_d, wr_j_q, wr_j_d;
  logic                    mode_q, mode_d;
  logic                    a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
  logic                    ap_idle_q, ap_idle_d, ap_done_q, ap_done_d;
  logic                    c_tvalid_q, c_tvalid_d, c_tlast_q, c_tlast_d;
  logic [CROW_W-1:0]       c_tdata_q, c_tdata_d;
  logic [ROW_W-1:0]        a_buf_q [DIM];
  logic [ROW_W-1:0]        a_buf_d [DIM];
  logic [ROW_W-1:0]        b_buf_q [DIM];
  logic [ROW_W-1:0]        b_buf_d [DIM];
  logic signed [ACC_W-1:0] c_buf_q [DIM][DIM];
  logic signed [ACC_W-1:0] c_buf_d [DIM][DIM];

  logic [DOT_W-1:0]        dot_q;
  logic signed [ACC_W-1:0] acc_old, acc_new;
  logic signed [SUM_W-1:0] acc_ext, dot_ext, sum_v;
  logic signed [63:0]      red_v;

  assign a_tready = a_rdy_q & ap_ce;
  assign b_tready = b_rdy_q & ap_ce;
  assign ap_ready = b_tready & b_tvalid & (beat_q == LAST_IDX);
  assign ap_idle  = ap_idle_q;
  assign ap_done  = ap_done_q;
  assign c_tvalid = c_tvalid_q;
  assign c_tlast  = c_tlast_q;
  assign c_tdata  = c_tdata_q;

  int8_dot_lane #(.DIM(DIM), .DOT_W(DOT_W)) u_lane (
    .clk         (ap_clk),
    .rst_n       (ap_rst_n),
    .ce          (ap_ce),
    .mode_signed (mode_q),
    .a_row       (a_buf_q[iss_i_q]),
    .b_col       (b_buf_q[iss_j_q]),
    .dot_q       (dot_q)
  );

  // Pack one stored C row into a stream beat.
  function automatic logic [CROW_W-1:0] pack_row(input logic [IDX_W-1:0] r);
    logic [CROW_W-1:0] row;
    row = '0;
    for (int j = 0; j < DIM; j++) begin
      row[j*ACC_W +: ACC_W] = c_buf_q[r][j];
    end
    return row;
  endfunction

  // Accumulator datapath: widen stored C and the lane result, add, then wrap or clamp to ACC_W.
  always_comb begin
    acc_old = c_buf_q[wr_i_q][wr_j_q];
    acc_ext = SUM_W'(acc_old);
    if (mode_q) begin
      dot_ext = SUM_W'($signed(dot_q));
    end else begin
      dot_ext = SUM_W'($unsigned(dot_q));
    end
    sum_v   = acc_ext + dot_ext;
    red_v   = acc_reduce(65'(sum_v), ACC_W);
    acc_new = red_v[ACC_W-1:0];
  end

  // Next-state logic for the control FSM, buffers, counters and stream outputs.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    iss_i_d    = iss_i_q;
    iss_j_d    = iss_j_q;
    iss_done_d = iss_done_q;
    wr_vld_d   = wr_vld_q;
    wr_i_d     = wr_i_q;
    wr_j_d     = wr_j_q;
    mode_d     = mode_q;
    a_rdy_d    = a_rdy_q;
    b_rdy_d    = b_rdy_q;
    ap_idle_d  = ap_idle_q;
    ap_done_d  = ap_done_q;
    c_tvalid_d = c_tvalid_q;
    c_tlast_d  = c_tlast_q;
    c_tdata_d  = c_tdata_q;
    a_buf_d    = a_buf_q;
    b_buf_d    = b_buf_q;
    c_buf_d    = c_buf_q;

    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          mode_d    = mode_signed;
          ap_idle_d = 1'b0;
          a_rdy_d   = 1'b1;
          beat_d    = '0;
          state_d   = S_RECV_A;
          if (!acc_en) begin
            for (int i = 0; i < DIM; i++) begin
              for (int j = 0; j < DIM; j++) begin
                c_buf_d[i][j] = '0;
              end
            end
          end
        end
      end
      S_RECV_A: begin
        if (a_tvalid && a_tready) begin
          a_buf_d[beat_q] = a_tdata;
          if (beat_q == LAST_IDX) begin
            beat_d  = '0;
            a_rdy_d = 1'b0;
            b_rdy_d = 1'b1;
            state_d = S_RECV_B;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_RECV_B: begin
        if (b_tvalid && b_tready) begin
          b_buf_d[beat_q] = b_tdata;
          if (beat_q == LAST_IDX) begin
            beat_d     = '0;
            b_rdy_d    = 1'b0;
            iss_i_d    = '0;
            iss_j_d    = '0;
            iss_done_d = 1'b0;
            wr_vld_d   = 1'b0;
            state_d    = S_COMPUTE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        wr_vld_d = 1'b0;
        if (!iss_done_q) begin
          wr_vld_d = 1'b1;
          wr_i_d   = iss_i_q;
          wr_j_d   = iss_j_q;
          if (iss_j_q == LAST_IDX) begin
            iss_j_d = '0;
            if (iss_i_q == LAST_IDX) begin
              iss_done_d = 1'b1;
            end else begin
              iss_i_d = iss_i_q + 1'b1;
            end
          end else begin
            iss_j_d = iss_j_q + 1'b1;
          end
        end
        if (wr_vld_q) begin
          c_buf_d[wr_i_q][wr_j_q] = acc_new;
          if (wr_i_q == LAST_IDX && wr_j_q == LAST_IDX) begin
            state_d    = S_SEND_C;
            beat_d     = '0;
            c_tvalid_d = 1'b1;
            c_tlast_d  = 1'b0;
            c_tdata_d  = pack_row('0);
          end
        end
      end
      S_SEND_C: begin
        if (c_tready) begin
          if (beat_q == LAST_IDX) begin
            c_tvalid_d = 1'b0;
            c_tlast_d  = 1'b0;
            ap_done_d  = 1'b1;
            state_d    = S_DONE;
          end else begin
            beat_d    = beat_q + 1'b1;
            c_tdata_d = pack_row(beat_q + 1'b1);
            c_tlast_d = ((beat_q + 1'b1) == LAST_IDX);
          end
        end
      end
      S_DONE: begin
        if (ap_continue) begin
          ap_done_d = 1'b0;
          ap_idle_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; everything freezes while ap_ce is low and clears on reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      iss_i_q    <= '0;
      iss_j_q    <= '0;
      iss_done_q <= 1'b0;
      wr_vld_q   <= 1'b0;
      wr_i_q     <= '0;
      wr_j_q     <= '0;
      mode_q     <= 1'b0;
      a_rdy_q    <= 1'b0;
      b_rdy_q    <= 1'b0;
      ap_idle_q  <= 1'b1;
      ap_done_q  <= 1'b0;
      c_tvalid_q <= 1'b0;
      c_tlast_q  <= 1'b0;
      c_tdata_q  <= '0;
      for (int i = 0; i < DIM; i++) begin
        a_buf_q[i] <= '0;
        b_buf_q[i] <= '0;
        for (int j = 0; j < DIM; j++) begin
          c_buf_q[i][j] <= '0;
        end
      end
    end else if (ap_ce) begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      iss_i_q    <= iss_i_d;
      iss_j_q    <= iss_j_d;
      iss_done_q <= iss_done_d;
      wr_vld_q   <= wr_vld_d;
      wr_i_q     <= wr_i_d;
      wr_j_q     <= wr_j_d;
      mode_q     <= mode_d;
      a_rdy_q    <= a_rdy_d;
      b_rdy_q    <= b_rdy_d;
      ap_idle_q  <= ap_idle_d;
      ap_done_q  <= ap_done_d;
      c_tvalid_q <= c_tvalid_d;
      c_tlast_q  <= c_tlast_d;
      c_tdata_q  <= c_tdata_d;
      a_buf_q    <= a_buf_d;
      b_buf_q    <= b_buf_d;
      c_buf_q    <= c_buf_d;
    end
  end

endmodule

// File: doc/int8_nxn_stream_mm.md
# int8_nxn_stream_mm

Parametrised INT8 matrix-multiply accelerator with an HLS-style block-level handshake (ap_ctrl_chain) and AXI-Stream-style data ports. It is the DIM×DIM generalisation of the fixed 8×8 INT8 black box. It adds:
- signed/unsigned operand mode;
- cross-call accumulation;
- correct output backpressure with a last-beat marker.

It sits behind Vitis HLS kernels as a black-box compute primitive.

## Interface
- DIM, 8: matrix dimension. Legal values 2..16.
- ACC_W, 32: width of each C element, two's complement. Must be ≥ 16.
- ap_clk  in  1  single clock; all logic rising-edge.
- ap_rst_n  in  1  reset, asynchronous assert, active-low.
- ap_ce  in  1  clock enable; low freezes all state and registered outputs.
- ap_start / ap_continue  in  1  block handshake.
- ap_idle / ap_ready / ap_done  out  1  block status.
- mode_signed  in  1  operand interpretation: 1 = signed int8, 0 = unsigned. Sampled at start.
- acc_en  in  1  accumulate mode: 1 = C += A·B, 0 = C = A·B. Sampled at start.
- a_tdata  in  DIM*8  one row of A per beat; element k at [k*8 +: 8].
- a_tvalid  in  1; a_tready  out  1.
- b_tdata  in  DIM*8  one column of B per beat; element k at [k*8 +: 8].
- b_tvalid  in  1; b_tready  out  1.
- c_tdata  out  DIM*ACC_W  one row of C per beat; element j at [j*ACC_W +: ACC_W].
- c_tvalid  out  1; c_tlast  out  1; c_tready  in  1.

## Operation
- States: IDLE → RECV_A → RECV_B → COMPUTE → SEND_C → DONE → IDLE.
- IDLE: on ap_start=1 with ap_ce=1:
  - latch mode_signed and acc_en;
  - zero the C buffer if acc_en=0;
  - go to RECV_A.
- RECV_A / RECV_B:
  - a_tready = (state==RECV_A) && ap_ce; b_tready likewise for RECV_B.
  - A beat is accepted on tvalid && tready, into row index 0..DIM-1, in order.
  - After DIM accepted beats, advance to the next state.
- ap_ready: one-cycle pulse in the cycle the last B beat is accepted. Inputs are consumed at that point; the caller may prepare the next call.
- COMPUTE: one C element per enabled cycle, row-major (i outer, j inner).
  - C[i][j] ← C[i][j] + dot(A row i, B col j).
  - Product: 8×8 → 16 bits. Dot sum: 16+clog2(DIM) bits, sign- or zero-extended per mode.
  - Accumulator add is performed at ACC_W+1 bits, then reduced to ACC_W (see Configuration).
- SEND_C:
  - Row r drives c_tdata; c_tlast=1 on row DIM-1.
  - Beat transfers on c_tvalid && c_tready.
  - c_tdata and c_tlast hold stable while c_tvalid && !c_tready.
  - c_tvalid never drops without a transfer (except on reset).
- DONE:
  - ap_done=1 (level).
  - On ap_continue=1 with ap_ce=1, return to IDLE.
  - The C buffer is retained for a later acc_en=1 call.
- ap_idle = (state==IDLE).
- ap_start outside IDLE is ignored.
- Reset mid-operation: state → IDLE, C buffer cleared, all outputs at reset values, in-flight data discarded.
- ap_ce=0: no beat accepted or issued, counters hold, outputs hold their last values. Exception: tready is forced low.

## Timing
- Reset values: ap_idle=1; ap_ready=0; ap_done=0; a_tready=0; b_tready=0; c_tvalid=0; c_tlast=0; c_tdata=0.
- With all valids/readies high and ap_ce=1, measured from the ap_start cycle:
  - RECV_A: DIM cycles.
  - RECV_B: DIM cycles.
  - COMPUTE: DIM*DIM+1 cycles (dot-lane output registered).
  - c_tvalid rises on the first SEND_C cycle.
  - Last C beat at cycle 2·DIM + DIM² + DIM + 1.
  - ap_done rises the next cycle.
- ap_continue asserted early (already high on DONE entry) still yields a ≥1-cycle ap_done.
- Each ap_ce=0 cycle extends total latency by exactly one cycle.

## Configuration
- INT8MM_SATURATE_EN defined: the accumulator result clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1] in both modes. The unsigned-mode result is still stored as signed.
- Not defined: the result wraps modulo 2^ACC_W (plain truncation).

## Structure
- Package int8mm_pkg holds:
  - state enum;
  - localparam helpers: row width DIM*8, C row width DIM*ACC_W, index width clog2(DIM);
  - saturate/wrap function.
- Sub-module int8_dot_lane (DIM, mode_signed):
  - DIM parallel 8×8 multipliers plus an adder tree;
  - one registered output, enable = ap_ce.
- Top module holds the FSM, the A/B/C buffers, the counters and the stream logic.

## Test plan
- DIM=8, signed. A = identity; B column j element k = k+8j. Required: C[i][j] = i+8j. Exactly 8 C beats; c_tlast only on the 8th; ap_done one cycle later.
- All A=0xFF, all B=0x01. Required: every C = −8 (0xFFFFFFF8) in signed mode and 2040 in unsigned mode.
- ACC_W=16, A=B=0x7F, signed. Required: C = 32767 with INT8MM_SATURATE_EN, and 0xF808 without it.
- Run A=I, B as in the first scenario, then repeat with acc_en=1. Required: second-run C[i][j] = 2(i+8j). A third run with acc_en=0 returns single values.
- Backpressure and clock enable:
  - c_tready toggling 1,0,1,0: c_tdata stable across stalls, no beat lost or duplicated.
  - ap_ce low for 5 cycles during COMPUTE: ap_done is delayed by exactly 5 cycles.
- ap_rst_n pulsed low mid-COMPUTE. Required: immediately ap_idle=1, c_tvalid=0, a_tready=0. A following acc_en=1 run returns plain A·B (buffer was cleared).
